// File: rtl/qe_sample_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : qe_sample_scheduler
// Brief    : Ticked sweep over QE channels: latch handshake, capture, wrap-safe delta.
// Revision : 1.0
// =============================================================================
module qe_sample_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [31:0]             period,
  output logic [NUM_CHANNELS-1:0] latch_req,
  input  logic [NUM_CHANNELS-1:0] latch_ack,
  input  logic [31:0]             count_in,
  input  logic [2:0]              rd_channel,
  output logic [31:0]             rd_position,
  output logic [31:0]             rd_delta,
  output logic                    sample_done,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] timeout_err,
  output logic                    overrun,
  input  logic                    clear_err
);
  localparam int                      WAIT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]              LAST_CH    = 3'(NUM_CHANNELS - 1);
  localparam logic [WAIT_W-1:0]       WAIT_LAST  = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [NUM_CHANNELS-1:0] CH0_ONEHOT = NUM_CHANNELS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_NEXT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              ch_q, ch_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [31:0]             timer_q, timer_d;
  logic                    enable_prev_q, enable_prev_d;
  logic [NUM_CHANNELS-1:0] primed_q, primed_d;
  logic [31:0]             position_q [NUM_CHANNELS];
  logic [31:0]             position_d [NUM_CHANNELS];
  logic [31:0]             delta_q    [NUM_CHANNELS];
  logic [31:0]             delta_d    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] latch_req_q, latch_req_d;
  logic [31:0]             rd_position_q, rd_position_d;
  logic [31:0]             rd_delta_q, rd_delta_d;
  logic                    sample_done_q, sample_done_d;
  logic                    busy_q, busy_d;
  logic [NUM_CHANNELS-1:0] timeout_err_q, timeout_err_d;
  logic                    overrun_q, overrun_d;

  logic                    tick;
  logic [NUM_CHANNELS-1:0] ch_sel;
  logic [NUM_CHANNELS-1:0] err_set;
  logic                    ovr_set;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    wait_d        = wait_q;
    timer_d       = timer_q;
    enable_prev_d = enable;
    primed_d      = primed_q;
    position_d    = position_q;
    delta_d       = delta_q;
    latch_req_d   = latch_req_q;
    sample_done_d = 1'b0;
    err_set       = '0;
    ovr_set       = 1'b0;
    tick          = 1'b0;

    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_sel[i] = (ch_q == 3'(i));
    end

    // Reload on enable rise and on every tick; period 0 parks the timer at 0.
    if (enable && !enable_prev_q) begin
      timer_d = (period == 32'd0) ? 32'd0 : period - 32'd1;
    end else if (enable) begin
      if (timer_q == 32'd0) begin
        if (period != 32'd0) begin
          tick    = 1'b1;
          timer_d = period - 32'd1;
        end
      end else begin
        timer_d = timer_q - 32'd1;
      end
    end

    if (!enable) begin
      state_d     = S_IDLE;
      latch_req_d = '0;
      primed_d    = '0;
    end else begin
      if (tick && state_q != S_IDLE) begin
        ovr_set = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_d     = S_REQ;
            ch_d        = 3'd0;
            wait_d      = '0;
            latch_req_d = CH0_ONEHOT;
          end
        end
        S_REQ: begin
          if (|(latch_ack & ch_sel)) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
              if (ch_sel[i]) begin
                position_d[i] = count_in;
                delta_d[i]    = primed_q[i] ? count_in - position_q[i] : 32'd0;
                primed_d[i]   = 1'b1;
              end
            end
            state_d     = S_NEXT;
            latch_req_d = '0;
          end else if (wait_q == WAIT_LAST) begin
            err_set     = ch_sel;
            state_d     = S_NEXT;
            latch_req_d = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (ch_q == LAST_CH) begin
            state_d       = S_DONE;
            sample_done_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            ch_d        = ch_q + 3'd1;
            wait_d      = '0;
            latch_req_d = CH0_ONEHOT << (ch_q + 3'd1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);

    // New errors win over a simultaneous clear.
    timeout_err_d = (clear_err ? '0 : timeout_err_q) | err_set;
    overrun_d     = (clear_err ? 1'b0 : overrun_q) | ovr_set;

    // Read from the next-state arrays so a same-edge capture is visible.
    rd_position_d = '0;
    rd_delta_d    = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_channel == 3'(i)) begin
        rd_position_d = position_d[i];
        rd_delta_d    = delta_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      wait_q        <= '0;
      timer_q       <= '0;
      enable_prev_q <= 1'b0;
      primed_q      <= '0;
      latch_req_q   <= '0;
      rd_position_q <= '0;
      rd_delta_q    <= '0;
      sample_done_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= '0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        position_q[i] <= '0;
        delta_q[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      wait_q        <= wait_d;
      timer_q       <= timer_d;
      enable_prev_q <= enable_prev_d;
      primed_q      <= primed_d;
      latch_req_q   <= latch_req_d;
      rd_position_q <= rd_position_d;
      rd_delta_q    <= rd_delta_d;
      sample_done_q <= sample_done_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        position_q[i] <= position_d[i];
        delta_q[i]    <= delta_d[i];
      end
    end
  end

  assign latch_req   = latch_req_q;
  assign rd_position = rd_position_q;
  assign rd_delta    = rd_delta_q;
  assign sample_done = sample_done_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire
